// File: rtl/hex_string_streamer.sv
// hex_string_streamer: formats one WIDTH-bit word as a handshaked ASCII hex string
// with optional "0x" prefix, terminator, case selection and leading-zero suppression.
module hex_string_streamer #(
    parameter int         WIDTH   = 32,
    parameter bit         PREFIX  = 1'b1,
    parameter bit         TERM_EN = 1'b1,
    parameter logic [7:0] TERM    = 8'h0A
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             lower,
    input  logic             zsup,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_char,
    output logic             out_last,
    output logic             busy
);
    localparam int NDIG = WIDTH / 4;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [2:0] {IDLE, PFX0, PFX1, DIG, TRM} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d, lead;
    logic             lower_q, lower_d;
    logic [IW-1:0]    idx_q, idx_d, start;
    logic [3:0]       nib;
    logic             accept, hs;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q != IDLE) && !rst;
    assign busy      = out_valid;
    assign accept    = in_valid && in_ready;
    assign hs        = out_valid && out_ready;
    assign nib       = data_q[WIDTH-1 -: 4];

    // The word is left-aligned on accept so the next digit is always the top nibble.
    always_comb begin
        lead  = in_data;
        start = IW'(NDIG - 1);
        for (int k = 0; k < NDIG - 1; k++) begin
            if (zsup && lead[WIDTH-1 -: 4] == 4'h0) begin
                lead  = lead << 4;
                start = start - IW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        lower_d = lower_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (accept) begin
                data_d  = lead;
                lower_d = lower;
                idx_d   = start;
                state_d = PREFIX ? PFX0 : DIG;
            end
            PFX0: if (hs) state_d = PFX1;
            PFX1: if (hs) state_d = DIG;
            DIG: if (hs) begin
                if (idx_q == '0) begin
                    state_d = TERM_EN ? TRM : IDLE;
                end else begin
                    idx_d  = idx_q - IW'(1);
                    data_d = data_q << 4;
                end
            end
            TRM: if (hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_char = 8'h00;
        out_last = 1'b0;
        if (!rst) begin
            case (state_q)
                PFX0: out_char = 8'h30;
                PFX1: out_char = 8'h78;
                DIG: begin
                    out_char = (nib < 4'd10) ? {4'h3, nib} : (lower_q ? 8'h60 : 8'h40) + {4'h0, nib - 4'd9};
                    out_last = !TERM_EN && (idx_q == '0);
                end
                TRM: begin
                    out_char = TERM;
                    out_last = 1'b1;
                end
                default: out_char = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            lower_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            lower_q <= lower_d;
            idx_q   <= idx_d;
        end
    end
endmodule

// File: tb/tb_hex_string_streamer.sv
// tb_hex_string_streamer: table vectors, reset abort sequence and randomized words
// checked against a string-building reference model.
module tb_hex_string_streamer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, lower, zsup, out_valid, out_ready, out_last, busy;
    logic [31:0] in_data;
    logic [7:0]  out_char;
    logic        s_in_valid, s_in_ready, s_lower, s_zsup, s_out_valid, s_out_ready, s_out_last, s_busy;
    logic [7:0]  s_in_data, s_out_char;

    int checks = 0;
    int failures = 0;
    logic [7:0] got_q[$];
    logic       last_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    hex_string_streamer #(.WIDTH(32), .PREFIX(1'b1), .TERM_EN(1'b1), .TERM(8'h0A)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .lower(lower), .zsup(zsup), .out_valid(out_valid), .out_ready(out_ready),
        .out_char(out_char), .out_last(out_last), .busy(busy));

    hex_string_streamer #(.WIDTH(8), .PREFIX(1'b0), .TERM_EN(1'b0), .TERM(8'h0A)) dut_s (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .lower(s_lower), .zsup(s_zsup), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_char(s_out_char), .out_last(s_out_last), .busy(s_busy));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] hexchr(input logic [3:0] n, input logic lw);
        return (n < 4'd10) ? 8'h30 + 8'(n) : (lw ? 8'h61 : 8'h41) + 8'(n) - 8'd10;
    endfunction

    function automatic void model(input logic [31:0] d, input logic lw, input logic zs);
        bit started = !zs;
        exp_q.delete();
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h78);
        for (int k = 7; k >= 0; k--) begin
            if (d[k*4 +: 4] != 4'h0 || k == 0) started = 1;
            if (started) exp_q.push_back(hexchr(d[k*4 +: 4], lw));
        end
        exp_q.push_back(8'h0A);
    endfunction

    task automatic compare(input string tag);
        chk({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_char%0d", tag, i), got_q[i], exp_q[i]);
            chk($sformatf("%s_last%0d", tag, i), last_q[i], i == exp_q.size() - 1);
        end
    endtask

    // Entered and left on a negedge with the block idle.
    task automatic run_str(input logic [31:0] d, input logic lw, input logic zs, input int rdy, input bit disturb);
        int cyc = 0;
        bit done = 0, stalled = 0;
        logic [7:0] pc = 8'h00;
        logic pl = 1'b0;
        got_q.delete();
        last_q.delete();
        chk("start_in_ready", in_ready, 1);
        in_valid = 1; in_data = d; lower = lw; zsup = zs;
        @(negedge clk);
        in_valid = 0;
        while (!done && cyc < 200) begin
            out_ready = $urandom_range(0, 99) < rdy;
            if (disturb) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = $urandom;
                lower    = 1'($urandom_range(0, 1));
                zsup     = 1'($urandom_range(0, 1));
            end
            chk("str_valid", out_valid, 1);
            chk("str_busy", busy, 1);
            chk("str_no_accept", in_ready, 0);
            if (stalled) begin
                chk("hold_char", out_char, pc);
                chk("hold_last", out_last, pl);
            end
            if (out_valid && out_ready) begin
                got_q.push_back(out_char);
                last_q.push_back(out_last);
                done = out_last;
            end
            stalled = out_valid && !out_ready;
            pc = out_char;
            pl = out_last;
            cyc++;
            @(negedge clk);
        end
        in_valid = 0;
        chk("str_finished", done, 1);
        if (rdy >= 100) chk("no_bubbles", cyc, got_q.size());
        chk("end_valid", out_valid, 0);
        chk("end_busy", busy, 0);
        chk("end_in_ready", in_ready, 1);
    endtask

    typedef struct {
        logic [31:0] d;
        logic        lw;
        logic        zs;
        int          rdy;
        bit          disturb;
        int          n;
        logic [87:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0]  d;
        logic        lw;
        logic        zs;
        int          n;
        logic [15:0] exp;
    } svec_t;

    initial begin
        vec_t  vt[6];
        svec_t st[4];
        vt[0] = '{32'h00C0FFEE, 1'b0, 1'b0, 100, 1'b0, 11, 88'h3078_3030_4330_4646_4545_0A};
        vt[1] = '{32'h00C0FFEE, 1'b1, 1'b1, 100, 1'b0, 9,  88'h3078_6330_6666_6565_0A00_00};
        vt[2] = '{32'h00000000, 1'b0, 1'b1, 100, 1'b0, 4,  88'h3078_300A_0000_0000_0000_00};
        vt[3] = '{32'hDEADBEEF, 1'b0, 1'b0, 50,  1'b1, 11, 88'h3078_4445_4144_4245_4546_0A};
        vt[4] = '{32'h0000ABCD, 1'b1, 1'b1, 50,  1'b1, 7,  88'h3078_6162_6364_0A00_0000_00};
        vt[5] = '{32'h00000000, 1'b0, 1'b0, 100, 1'b0, 11, 88'h3078_3030_3030_3030_3030_0A};
        st[0] = '{8'hA5, 1'b0, 1'b0, 2, 16'h4135};
        st[1] = '{8'h0B, 1'b1, 1'b1, 1, 16'h6200};
        st[2] = '{8'h00, 1'b0, 1'b1, 1, 16'h3000};
        st[3] = '{8'h0B, 1'b0, 1'b0, 2, 16'h3042};

        rst = 1; in_valid = 0; in_data = '0; lower = 0; zsup = 0; out_ready = 0;
        s_in_valid = 0; s_in_data = '0; s_lower = 0; s_zsup = 0; s_out_ready = 1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_char", out_char, 8'h00);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_s_in_ready", s_in_ready, 0);
        rst = 0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_s_in_ready", s_in_ready, 1);

        foreach (vt[v]) begin
            run_str(vt[v].d, vt[v].lw, vt[v].zs, vt[v].rdy, vt[v].disturb);
            exp_q.delete();
            for (int i = 0; i < vt[v].n; i++) exp_q.push_back(vt[v].exp[87 - 8*i -: 8]);
            compare($sformatf("vec%0d", v));
        end

        // Reset after four characters must abort the string and drop the word.
        in_valid = 1; in_data = 32'h12345678; lower = 0; zsup = 0; out_ready = 1;
        @(negedge clk);
        in_valid = 0;
        repeat (4) @(negedge clk);
        chk("pre_abort_char", out_char, 8'h33);
        rst = 1;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("after_abort_valid", out_valid, 0);
        chk("after_abort_busy", busy, 0);
        chk("after_abort_in_ready", in_ready, 1);
        @(negedge clk);
        run_str(32'h00000001, 1'b0, 1'b0, 100, 1'b0);
        model(32'h00000001, 1'b0, 1'b0);
        compare("post_abort");

        foreach (st[v]) begin
            chk("s_in_ready", s_in_ready, 1);
            s_in_valid = 1; s_in_data = st[v].d; s_lower = st[v].lw; s_zsup = st[v].zs;
            @(negedge clk);
            s_in_valid = 0;
            for (int i = 0; i < st[v].n; i++) begin
                chk($sformatf("s%0d_valid%0d", v, i), s_out_valid, 1);
                chk($sformatf("s%0d_char%0d", v, i), s_out_char, st[v].exp[15 - 8*i -: 8]);
                chk($sformatf("s%0d_last%0d", v, i), s_out_last, i == st[v].n - 1);
                @(negedge clk);
            end
            chk($sformatf("s%0d_busy_end", v), s_busy, 0);
            chk($sformatf("s%0d_valid_end", v), s_out_valid, 0);
        end

        for (int r = 0; r < 40; r++) begin
            logic [31:0] d = $urandom;
            int sh = $urandom_range(0, 32);
            logic lw = 1'($urandom_range(0, 1));
            logic zs = 1'($urandom_range(0, 1));
            d = (sh == 32) ? 32'h0 : d >> sh;
            run_str(d, lw, zs, ($urandom_range(0, 1) != 0) ? 100 : 50, bit'($urandom_range(0, 1)));
            model(d, lw, zs);
            compare($sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
